// File: rtl/addressdecode_pkg.sv
// Shared definitions for the address decode engine: window mode encoding,
// configuration field selects, FSM states and the per-window attribute record.
package addressdecode_pkg;

  // Window access modes
  localparam logic [1:0] MODE_WR  = 2'b00;
  localparam logic [1:0] MODE_RD  = 2'b01;
  localparam logic [1:0] MODE_RW  = 2'b10;
  localparam logic [1:0] MODE_OFF = 2'b11;

  // cfg_sel field selects
  localparam logic [1:0] CFG_BASE = 2'd0;
  localparam logic [1:0] CFG_MASK = 2'd1;
  localparam logic [1:0] CFG_ATTR = 2'd2;
  localparam logic [1:0] CFG_RSVD = 2'd3;

  // Storage width of the slot field; the engine keeps SLOT_W bits of it meaningful
  localparam int ATTR_SLOT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MATCH = 2'd1,
    ST_HIT   = 2'd2,
    ST_MISS  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ATTR_SLOT_W-1:0] slot;
    logic [1:0]             mode;
  } attr_t;

  // True when the captured direction (1 = read) is permitted by the window mode
  function automatic logic op_ok(input logic [1:0] mode, input logic rw);
    case (mode)
      MODE_WR: op_ok = !rw;
      MODE_RD: op_ok = rw;
      MODE_RW: op_ok = 1'b1;
      default: op_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/addressdecode_prio.sv
// Combinational window match over the registered table with lowest-index
// priority: reports whether any window hits and which one wins.
module addressdecode_prio
  import addressdecode_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int NUM_WIN     = 16,
  parameter int WIN_INDEX_W = 4
) (
  input  logic [ADDR_W-1:0]      addr_q,
  input  logic                   rw_q,
  input  logic [ADDR_W-1:0]      base_tab [NUM_WIN],
  input  logic [ADDR_W-1:0]      mask_tab [NUM_WIN],
  input  logic [1:0]             mode_tab [NUM_WIN],
  output logic                   hit_any,
  output logic [WIN_INDEX_W-1:0] hit_idx
);

  // Scan from the top index down so the lowest hitting window is the last one written
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int w = NUM_WIN - 1; w >= 0; w--) begin
      if ((mode_tab[w] != MODE_OFF) &&
          (((addr_q ^ base_tab[w]) & mask_tab[w]) == '0) &&
          op_ok(mode_tab[w], rw_q)) begin
        hit_any = 1'b1;
        hit_idx = WIN_INDEX_W'(w);
      end
    end
  end

endmodule

// File: rtl/addressdecode_engine.sv
// Registered, programmable I/O address decoder. Captures the bus address when
// iorq_n falls, resolves it against a runtime-writable window table on the next
// edge and holds the resulting slot select until iorq_n rises. Unmatched cycles
// are recorded as a sticky flag, last miss address and saturating count.
// Optional build macro ADDRDEC_HITCNT_EN adds per-window 16-bit hit counters
// readable through hit_cnt_rd (cfg_sel = 3 selects, a cfg_sel = 3 write clears).
module addressdecode_engine
  import addressdecode_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int NUM_WIN     = 16,
  parameter int WIN_INDEX_W = 4,
  parameter int NUM_SLOTS   = 8,
  parameter int SLOT_W      = 3,
  parameter int MISS_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   iorq_n,
  input  logic                   r_w_,
  input  logic                   cfg_we,
  input  logic [WIN_INDEX_W-1:0] cfg_win,
  input  logic [1:0]             cfg_sel,
  input  logic [ADDR_W-1:0]      cfg_wdata,
  output logic                   cfg_busy,
  input  logic                   miss_clr,
  output logic                   dec_valid,
  output logic [WIN_INDEX_W-1:0] dec_win,
  output logic [SLOT_W-1:0]      dec_slot,
  output logic [NUM_SLOTS-1:0]   slot_sel_n,
  output logic                   miss_flag,
  output logic [ADDR_W-1:0]      miss_addr,
  output logic [MISS_CNT_W-1:0]  miss_cnt
`ifdef ADDRDEC_HITCNT_EN
  ,
  output logic [15:0]            hit_cnt_rd
`endif
);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;

  logic [ADDR_W-1:0] base_tab [NUM_WIN];
  logic [ADDR_W-1:0] mask_tab [NUM_WIN];
  attr_t             attr_tab [NUM_WIN];
  logic [1:0]        mode_tab [NUM_WIN];

  logic                   hit_any;
  logic [WIN_INDEX_W-1:0] hit_idx;
  logic [ATTR_SLOT_W-1:0] win_slot;
  logic [NUM_SLOTS-1:0]   win_sel_n;

  logic capture, take_hit, take_miss, leave_hit, cfg_ok;

  function automatic logic [MISS_CNT_W-1:0] sat_inc_miss(input logic [MISS_CNT_W-1:0] v);
    sat_inc_miss = (&v) ? v : v + MISS_CNT_W'(1);
  endfunction

  addressdecode_prio #(
    .ADDR_W      (ADDR_W),
    .NUM_WIN     (NUM_WIN),
    .WIN_INDEX_W (WIN_INDEX_W)
  ) u_prio (
    .addr_q   (addr_q),
    .rw_q     (rw_q),
    .base_tab (base_tab),
    .mask_tab (mask_tab),
    .mode_tab (mode_tab),
    .hit_any  (hit_any),
    .hit_idx  (hit_idx)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: a single high sample of iorq_n always returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!iorq_n) state_nxt = ST_MATCH;
      ST_MATCH: begin
        if (iorq_n)       state_nxt = ST_IDLE;
        else if (hit_any) state_nxt = ST_HIT;
        else              state_nxt = ST_MISS;
      end
      ST_HIT:   if (iorq_n) state_nxt = ST_IDLE;
      ST_MISS:  if (iorq_n) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Control strobes derived from the current state and bus/config inputs
  always_comb begin
    capture   = 1'b0;
    take_hit  = 1'b0;
    take_miss = 1'b0;
    leave_hit = 1'b0;
    cfg_busy  = (state == ST_MATCH);
    cfg_ok    = cfg_we && (state != ST_MATCH) && (int'(cfg_win) < NUM_WIN);
    case (state)
      ST_IDLE:  capture = !iorq_n;
      ST_MATCH: begin
        take_hit  = !iorq_n && hit_any;
        take_miss = !iorq_n && !hit_any;
      end
      ST_HIT:   leave_hit = iorq_n;
      default:  ;
    endcase
  end

  // Winning window's slot and its one-hot active-low select; out-of-range slots select nothing
  always_comb begin
    win_slot = attr_tab[hit_idx].slot;
    for (int s = 0; s < NUM_SLOTS; s++) win_sel_n[s] = (int'(win_slot) != s);
    for (int w = 0; w < NUM_WIN; w++) mode_tab[w] = attr_tab[w].mode;
  end

  // Window table: reset to all-disabled, written outside MATCH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WIN; w++) begin
        base_tab[w] <= '0;
        mask_tab[w] <= '0;
        attr_tab[w] <= '{slot: '0, mode: MODE_OFF};
      end
    end else if (cfg_ok) begin
      case (cfg_sel)
        CFG_BASE: base_tab[cfg_win] <= cfg_wdata;
        CFG_MASK: mask_tab[cfg_win] <= cfg_wdata;
        CFG_ATTR: begin
          attr_tab[cfg_win].slot <= ATTR_SLOT_W'(cfg_wdata[SLOT_W-1:0]);
          attr_tab[cfg_win].mode <= cfg_wdata[SLOT_W+1:SLOT_W];
        end
        default: ;
      endcase
    end
  end

  // Bus cycle capture on the falling iorq_n sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      rw_q   <= 1'b0;
    end else if (capture) begin
      addr_q <= addr;
      rw_q   <= r_w_;
    end
  end

  // Decode outputs: loaded on a hit, cleared on the edge that leaves HIT
  always_ff @(posedge clk) begin
    if (!rst_n || leave_hit) begin
      dec_valid  <= 1'b0;
      dec_win    <= '0;
      dec_slot   <= '0;
      slot_sel_n <= '1;
    end else if (take_hit) begin
      dec_valid  <= 1'b1;
      dec_win    <= hit_idx;
      dec_slot   <= SLOT_W'(win_slot);
      slot_sel_n <= win_sel_n;
    end
  end

  // Miss tracking: a coincident clear is applied before the new miss is counted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miss_flag <= 1'b0;
      miss_addr <= '0;
      miss_cnt  <= '0;
    end else if (take_miss) begin
      miss_flag <= 1'b1;
      miss_addr <= addr_q;
      miss_cnt  <= miss_clr ? MISS_CNT_W'(1) : sat_inc_miss(miss_cnt);
    end else if (miss_clr) begin
      miss_flag <= 1'b0;
      miss_cnt  <= '0;
    end
  end

`ifdef ADDRDEC_HITCNT_EN
  logic [15:0] hit_cnt [NUM_WIN];

  function automatic logic [15:0] sat_inc_hit(input logic [15:0] v);
    sat_inc_hit = (&v) ? v : v + 16'd1;
  endfunction

  // Per-window hit statistics with a registered read port selected by cfg_sel = 3
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WIN; w++) hit_cnt[w] <= '0;
      hit_cnt_rd <= '0;
    end else begin
      if (take_hit) hit_cnt[hit_idx] <= sat_inc_hit(hit_cnt[hit_idx]);
      if (cfg_ok && (cfg_sel == CFG_RSVD)) hit_cnt[cfg_win] <= '0;
      if ((cfg_sel == CFG_RSVD) && (int'(cfg_win) < NUM_WIN)) hit_cnt_rd <= hit_cnt[cfg_win];
    end
  end
`endif

endmodule

// File: tb/tb_addressdecode_engine.sv
// Self-checking bench for addressdecode_engine: directed scenarios plus a
// randomized run, all compared against a table-based reference model.
module tb_addressdecode_engine;

  localparam int ADDR_W      = 32;
  localparam int NUM_WIN     = 12;
  localparam int WIN_INDEX_W = 4;
  localparam int NUM_SLOTS   = 8;
  localparam int SLOT_W      = 3;
  localparam int MISS_CNT_W  = 8;
  localparam int MAXC        = (1 << MISS_CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [ADDR_W-1:0]      addr;
  logic                   iorq_n;
  logic                   r_w_;
  logic                   cfg_we;
  logic [WIN_INDEX_W-1:0] cfg_win;
  logic [1:0]             cfg_sel;
  logic [ADDR_W-1:0]      cfg_wdata;
  logic                   cfg_busy;
  logic                   miss_clr;
  logic                   dec_valid;
  logic [WIN_INDEX_W-1:0] dec_win;
  logic [SLOT_W-1:0]      dec_slot;
  logic [NUM_SLOTS-1:0]   slot_sel_n;
  logic                   miss_flag;
  logic [ADDR_W-1:0]      miss_addr;
  logic [MISS_CNT_W-1:0]  miss_cnt;

  always #5 clk = ~clk;

  addressdecode_engine #(
    .ADDR_W      (ADDR_W),
    .NUM_WIN     (NUM_WIN),
    .WIN_INDEX_W (WIN_INDEX_W),
    .NUM_SLOTS   (NUM_SLOTS),
    .SLOT_W      (SLOT_W),
    .MISS_CNT_W  (MISS_CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .iorq_n     (iorq_n),
    .r_w_       (r_w_),
    .cfg_we     (cfg_we),
    .cfg_win    (cfg_win),
    .cfg_sel    (cfg_sel),
    .cfg_wdata  (cfg_wdata),
    .cfg_busy   (cfg_busy),
    .miss_clr   (miss_clr),
    .dec_valid  (dec_valid),
    .dec_win    (dec_win),
    .dec_slot   (dec_slot),
    .slot_sel_n (slot_sel_n),
    .miss_flag  (miss_flag),
    .miss_addr  (miss_addr),
    .miss_cnt   (miss_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the window table and miss statistics as plain values
  logic [31:0] m_base [16];
  logic [31:0] m_mask [16];
  int          m_slot [16];
  int          m_mode [16];
  logic        m_flag;
  logic [31:0] m_addr;
  int          m_cnt;

  // Expected decode for the most recent modelled cycle
  logic       ev;
  logic [3:0] ew;
  logic [2:0] es;
  logic [7:0] esel;

  logic [31:0] mask_choice [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_base[i] = '0; m_mask[i] = '0; m_slot[i] = 0; m_mode[i] = 3;
    end
    m_flag = 1'b0; m_addr = '0; m_cnt = 0;
  endtask

  task automatic cfg_write(input int win, input int sel, input logic [31:0] data);
    cfg_we = 1'b1; cfg_win = 4'(win); cfg_sel = 2'(sel); cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
    if (win < NUM_WIN) begin
      case (sel)
        0: m_base[win] = data;
        1: m_mask[win] = data;
        2: begin m_slot[win] = int'(data[2:0]); m_mode[win] = int'(data[4:3]); end
        default: ;
      endcase
    end
  endtask

  // Compute the expected outcome of one bus cycle and advance the miss model
  task automatic ref_decide(input logic [31:0] a, input logic rw, input logic clr);
    logic ok;
    ev = 1'b0; ew = '0; es = '0; esel = '1;
    for (int i = 0; i < NUM_WIN; i++) begin
      ok = (m_mode[i] == 2) || (m_mode[i] == 0 && !rw) || (m_mode[i] == 1 && rw);
      if (!ev && ok && ((a ^ m_base[i]) & m_mask[i]) == 32'd0) begin
        ev = 1'b1; ew = 4'(i); es = 3'(m_slot[i]);
      end
    end
    if (ev && int'(es) < NUM_SLOTS) esel[es] = 1'b0;
    if (clr) begin m_flag = 1'b0; m_cnt = 0; end
    if (!ev) begin
      m_flag = 1'b1; m_addr = a;
      m_cnt = (m_cnt >= MAXC) ? MAXC : m_cnt + 1;
    end
  endtask

  // Drive a bus cycle up to and including its decision edge
  task automatic start_cycle(input logic [31:0] a, input logic rw, input logic clr);
    addr = a; r_w_ = rw; iorq_n = 1'b0;
    tick();
    miss_clr = clr;
    tick();
    miss_clr = 1'b0;
  endtask

  task automatic end_cycle();
    iorq_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({dec_valid, dec_win, dec_slot, slot_sel_n, cfg_busy} !== {1'b0, 4'd0, 3'd0, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL reset_decode: got %b expected %b", {dec_valid, dec_win, dec_slot, slot_sel_n, cfg_busy}, {1'b0, 4'd0, 3'd0, 8'hFF, 1'b0});
    end
    checks++;
    if ({miss_flag, miss_addr, miss_cnt} !== {1'b0, 32'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_miss: got %h expected 0", {miss_flag, miss_addr, miss_cnt});
    end
    rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic test_basic_hit();
    cfg_write(0, 0, 32'h0000_1000);
    cfg_write(0, 1, 32'hFFFF_F000);
    cfg_write(0, 2, 32'h13);
    addr = 32'h1234; r_w_ = 1'b1; iorq_n = 1'b0;
    tick();
    checks++;
    if ({cfg_busy, dec_valid, slot_sel_n} !== {1'b1, 1'b0, 8'hFF}) begin
      errors++;
      $display("FAIL match_stage: got %b expected %b", {cfg_busy, dec_valid, slot_sel_n}, {1'b1, 1'b0, 8'hFF});
    end
    tick();
    checks++;
    if ({dec_valid, dec_win, dec_slot, slot_sel_n} !== {1'b1, 4'd0, 3'd3, 8'b1111_0111}) begin
      errors++;
      $display("FAIL basic_hit: got %h expected %h", {dec_valid, dec_win, dec_slot, slot_sel_n}, {1'b1, 4'd0, 3'd3, 8'b1111_0111});
    end
    tick();
    checks++;
    if ({dec_valid, slot_sel_n, cfg_busy} !== {1'b1, 8'b1111_0111, 1'b0}) begin
      errors++;
      $display("FAIL basic_hold: got %b expected %b", {dec_valid, slot_sel_n, cfg_busy}, {1'b1, 8'b1111_0111, 1'b0});
    end
    end_cycle();
    checks++;
    if ({dec_valid, dec_win, dec_slot, slot_sel_n} !== {1'b0, 4'd0, 3'd0, 8'hFF}) begin
      errors++;
      $display("FAIL basic_release: got %h expected %h", {dec_valid, dec_win, dec_slot, slot_sel_n}, {1'b0, 4'd0, 3'd0, 8'hFF});
    end
  endtask

  task automatic test_priority();
    cfg_write(2, 0, 32'h0000_1000);
    cfg_write(2, 1, 32'hFFFF_F000);
    cfg_write(2, 2, 32'h15);
    ref_decide(32'h1010, 1'b1, 1'b0);
    start_cycle(32'h1010, 1'b1, 1'b0);
    checks++;
    if ({dec_valid, dec_win, dec_slot, slot_sel_n} !== {1'b1, 4'd0, 3'd3, 8'hF7} ||
        {ev, ew, es, esel} !== {1'b1, 4'd0, 3'd3, 8'hF7}) begin
      errors++;
      $display("FAIL prio_lowest: got %h expected %h", {dec_valid, dec_win, dec_slot, slot_sel_n}, {1'b1, 4'd0, 3'd3, 8'hF7});
    end
    end_cycle();
    cfg_write(0, 2, 32'h1B);
    start_cycle(32'h1010, 1'b1, 1'b0);
    checks++;
    if ({dec_valid, dec_win, dec_slot, slot_sel_n} !== {1'b1, 4'd2, 3'd5, 8'hDF}) begin
      errors++;
      $display("FAIL prio_next: got %h expected %h", {dec_valid, dec_win, dec_slot, slot_sel_n}, {1'b1, 4'd2, 3'd5, 8'hDF});
    end
    end_cycle();
  endtask

  task automatic test_mode_miss();
    cfg_write(0, 2, 32'h0B);
    cfg_write(2, 2, 32'h1D);
    ref_decide(32'h1000, 1'b0, 1'b0);
    start_cycle(32'h1000, 1'b0, 1'b0);
    checks++;
    if ({dec_valid, slot_sel_n} !== {1'b0, 8'hFF}) begin
      errors++;
      $display("FAIL mode_nosel: got %b expected %b", {dec_valid, slot_sel_n}, {1'b0, 8'hFF});
    end
    checks++;
    if ({miss_flag, miss_addr, miss_cnt} !== {1'b1, 32'h1000, 8'd1}) begin
      errors++;
      $display("FAIL mode_miss: got %h expected %h", {miss_flag, miss_addr, miss_cnt}, {1'b1, 32'h1000, 8'd1});
    end
    end_cycle();
    ref_decide(32'h1000, 1'b1, 1'b0);
    start_cycle(32'h1000, 1'b1, 1'b0);
    checks++;
    if ({dec_valid, dec_win, dec_slot, slot_sel_n, miss_cnt} !== {1'b1, 4'd0, 3'd3, 8'hF7, 8'd1}) begin
      errors++;
      $display("FAIL mode_read_ok: got %h expected %h", {dec_valid, dec_win, dec_slot, slot_sel_n, miss_cnt}, {1'b1, 4'd0, 3'd3, 8'hF7, 8'd1});
    end
    end_cycle();
  endtask

  task automatic test_saturation();
    while (m_cnt < MAXC - 1) begin
      ref_decide(32'hDEAD_0000, 1'b1, 1'b0);
      start_cycle(32'hDEAD_0000, 1'b1, 1'b0);
      end_cycle();
    end
    checks++;
    if (miss_cnt !== MISS_CNT_W'(MAXC - 1)) begin
      errors++;
      $display("FAIL sat_preload: got %h expected %h", miss_cnt, MISS_CNT_W'(MAXC - 1));
    end
    for (int k = 0; k < 3; k++) begin
      ref_decide(32'hBEEF_0000 + 32'(k), 1'b0, 1'b0);
      start_cycle(32'hBEEF_0000 + 32'(k), 1'b0, 1'b0);
      end_cycle();
    end
    checks++;
    if ({miss_flag, miss_addr, miss_cnt} !== {1'b1, 32'hBEEF_0002, 8'hFF}) begin
      errors++;
      $display("FAIL sat_hold: got %h expected %h", {miss_flag, miss_addr, miss_cnt}, {1'b1, 32'hBEEF_0002, 8'hFF});
    end
    ref_decide(32'hCAFE_0000, 1'b1, 1'b1);
    start_cycle(32'hCAFE_0000, 1'b1, 1'b1);
    checks++;
    if ({miss_flag, miss_addr, miss_cnt} !== {1'b1, 32'hCAFE_0000, 8'd1}) begin
      errors++;
      $display("FAIL clr_with_miss: got %h expected %h", {miss_flag, miss_addr, miss_cnt}, {1'b1, 32'hCAFE_0000, 8'd1});
    end
    end_cycle();
    miss_clr = 1'b1;
    tick();
    miss_clr = 1'b0;
    m_flag = 1'b0; m_cnt = 0;
    checks++;
    if ({miss_flag, miss_addr, miss_cnt} !== {1'b0, 32'hCAFE_0000, 8'd0}) begin
      errors++;
      $display("FAIL clr_idle: got %h expected %h", {miss_flag, miss_addr, miss_cnt}, {1'b0, 32'hCAFE_0000, 8'd0});
    end
  endtask

  task automatic test_abort();
    logic [31:0] a [2];
    a[0] = 32'h1000;
    a[1] = 32'h7777_0000;
    for (int k = 0; k < 2; k++) begin
      addr = a[k]; r_w_ = 1'b1; iorq_n = 1'b0;
      tick();
      iorq_n = 1'b1;
      tick();
      checks++;
      if ({dec_valid, slot_sel_n, cfg_busy, miss_flag, miss_addr, miss_cnt} !==
          {1'b0, 8'hFF, 1'b0, m_flag, m_addr, MISS_CNT_W'(m_cnt)}) begin
        errors++;
        $display("FAIL abort_%0d: got %h expected %h", k, {dec_valid, slot_sel_n, cfg_busy, miss_flag, miss_addr, miss_cnt},
                 {1'b0, 8'hFF, 1'b0, m_flag, m_addr, MISS_CNT_W'(m_cnt)});
      end
    end
  endtask

  task automatic test_cfg_timing();
    cfg_write(0, 2, 32'h13);
    start_cycle(32'h1000, 1'b1, 1'b0);
    cfg_write(0, 2, 32'h11);
    checks++;
    if ({dec_valid, dec_slot, slot_sel_n} !== {1'b1, 3'd3, 8'hF7}) begin
      errors++;
      $display("FAIL held_decision: got %h expected %h", {dec_valid, dec_slot, slot_sel_n}, {1'b1, 3'd3, 8'hF7});
    end
    end_cycle();
    start_cycle(32'h1000, 1'b1, 1'b0);
    checks++;
    if ({dec_valid, dec_slot, slot_sel_n} !== {1'b1, 3'd1, 8'hFD}) begin
      errors++;
      $display("FAIL new_slot: got %h expected %h", {dec_valid, dec_slot, slot_sel_n}, {1'b1, 3'd1, 8'hFD});
    end
    end_cycle();
    addr = 32'h1000; r_w_ = 1'b1; iorq_n = 1'b0;
    tick();
    cfg_we = 1'b1; cfg_win = 4'd0; cfg_sel = 2'd2; cfg_wdata = 32'h1B;
    tick();
    cfg_we = 1'b0;
    end_cycle();
    cfg_write(0, 3, 32'h1B);
    cfg_write(13, 2, 32'h1B);
    ref_decide(32'h1000, 1'b1, 1'b0);
    start_cycle(32'h1000, 1'b1, 1'b0);
    checks++;
    if ({dec_valid, dec_win, dec_slot, slot_sel_n} !== {1'b1, 4'd0, 3'd1, 8'hFD} ||
        {dec_valid, dec_win, dec_slot, slot_sel_n} !== {ev, ew, es, esel}) begin
      errors++;
      $display("FAIL ignored_writes: got %h expected %h", {dec_valid, dec_win, dec_slot, slot_sel_n}, {1'b1, 4'd0, 3'd1, 8'hFD});
    end
    end_cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int k = 0; k < 6; k++) begin
      a = (k % 2 == 0) ? 32'h1000 + 32'(k) : 32'h5000 + 32'(k);
      ref_decide(a, 1'b1, 1'b0);
      start_cycle(a, 1'b1, 1'b0);
      checks++;
      if ({dec_valid, dec_win, dec_slot, slot_sel_n, miss_flag, miss_addr, miss_cnt} !==
          {ev, ew, es, esel, m_flag, m_addr, MISS_CNT_W'(m_cnt)}) begin
        errors++;
        $display("FAIL b2b_%0d: got %h expected %h", k, {dec_valid, dec_win, dec_slot, slot_sel_n, miss_flag, miss_addr, miss_cnt},
                 {ev, ew, es, esel, m_flag, m_addr, MISS_CNT_W'(m_cnt)});
      end
      end_cycle();
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic rw, clr;
    int win, sel, hold;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        win = $urandom_range(0, 15);
        sel = $urandom_range(0, 3);
        case (sel)
          0: d = 32'($urandom_range(0, 15)) << 12;
          1: d = mask_choice[$urandom_range(0, 4)];
          2: d = 32'($urandom_range(0, 31));
          default: d = $urandom;
        endcase
        cfg_write(win, sel, d);
      end
      a  = (32'($urandom_range(0, 15)) << 12) | 32'($urandom_range(0, 4095));
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        addr = a; r_w_ = rw; iorq_n = 1'b0;
        tick();
        iorq_n = 1'b1;
        tick();
        checks++;
        if ({dec_valid, slot_sel_n, miss_flag, miss_addr, miss_cnt} !== {1'b0, 8'hFF, m_flag, m_addr, MISS_CNT_W'(m_cnt)}) begin
          errors++;
          $display("FAIL rand_abort_%0d: got %h expected %h", n, {dec_valid, slot_sel_n, miss_flag, miss_addr, miss_cnt},
                   {1'b0, 8'hFF, m_flag, m_addr, MISS_CNT_W'(m_cnt)});
        end
      end else begin
        clr  = ($urandom_range(0, 9) == 0);
        hold = $urandom_range(0, 2);
        ref_decide(a, rw, clr);
        start_cycle(a, rw, clr);
        for (int h = 0; h <= hold; h++) begin
          checks++;
          if ({dec_valid, dec_win, dec_slot, slot_sel_n, miss_flag, miss_addr, miss_cnt} !==
              {ev, ew, es, esel, m_flag, m_addr, MISS_CNT_W'(m_cnt)}) begin
            errors++;
            $display("FAIL rand_%0d_%0d: got %h expected %h", n, h, {dec_valid, dec_win, dec_slot, slot_sel_n, miss_flag, miss_addr, miss_cnt},
                     {ev, ew, es, esel, m_flag, m_addr, MISS_CNT_W'(m_cnt)});
          end
          if (h < hold) tick();
        end
        end_cycle();
        checks++;
        if ({dec_valid, dec_win, dec_slot, slot_sel_n} !== {1'b0, 4'd0, 3'd0, 8'hFF}) begin
          errors++;
          $display("FAIL rand_exit_%0d: got %h expected %h", n, {dec_valid, dec_win, dec_slot, slot_sel_n}, {1'b0, 4'd0, 3'd0, 8'hFF});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    cfg_write(0, 0, 32'h1000);
    cfg_write(0, 1, 32'hFFFF_F000);
    cfg_write(0, 2, 32'h13);
    start_cycle(32'h1000, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    checks++;
    if ({dec_valid, dec_win, dec_slot, slot_sel_n, miss_flag, miss_addr, miss_cnt, cfg_busy} !==
        {1'b0, 4'd0, 3'd0, 8'hFF, 1'b0, 32'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got %h expected %h", {dec_valid, dec_win, dec_slot, slot_sel_n, miss_flag, miss_addr, miss_cnt, cfg_busy},
               {1'b0, 4'd0, 3'd0, 8'hFF, 1'b0, 32'd0, 8'd0, 1'b0});
    end
    rst_n = 1'b1; iorq_n = 1'b1;
    tick();
    model_reset();
    ref_decide(32'h1000, 1'b1, 1'b0);
    start_cycle(32'h1000, 1'b1, 1'b0);
    checks++;
    if ({dec_valid, slot_sel_n, miss_flag, miss_addr, miss_cnt} !== {1'b0, 8'hFF, 1'b1, 32'h1000, 8'd1}) begin
      errors++;
      $display("FAIL reset_table: got %h expected %h", {dec_valid, slot_sel_n, miss_flag, miss_addr, miss_cnt}, {1'b0, 8'hFF, 1'b1, 32'h1000, 8'd1});
    end
    end_cycle();
  endtask

  initial begin
    mask_choice[0] = 32'hFFFF_F000;
    mask_choice[1] = 32'hFFFF_0000;
    mask_choice[2] = 32'h0000_F000;
    mask_choice[3] = 32'h0000_0000;
    mask_choice[4] = 32'hFFFF_FFFF;
    rst_n = 1'b0; addr = '0; iorq_n = 1'b1; r_w_ = 1'b1;
    cfg_we = 1'b0; cfg_win = '0; cfg_sel = '0; cfg_wdata = '0; miss_clr = 1'b0;
    model_reset();
    test_reset();
    test_basic_hit();
    test_priority();
    test_mode_miss();
    test_saturation();
    test_abort();
    test_cfg_timing();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
